// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the rate-1/2, K=3 hard-decision Viterbi decoder.
package viterbi_pkg;

    localparam int unsigned NUM_STATES = 4;

    typedef logic [1:0] state_t;
    typedef logic [1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE,
        ACS,
        TRACE,
        OUT
    } fsm_t;

    // Encoder output for transition {p,x} -> {x,b}: [1]=p^x (G1), [0]=p^b (G0)
    function automatic sym_t expected_sym(input logic p, input logic x, input logic b);
        return {p ^ x, p ^ b};
    endfunction

    function automatic logic [1:0] hamming(input sym_t a, input sym_t b);
        sym_t d;
        d = a ^ b;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

endpackage

// File: rtl/viterbi_decoder_acs.sv
// Combinational add-compare-select for all four trellis states, saturating at all-ones.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W = 9
) (
    input  logic [NUM_STATES-1:0][PM_W-1:0] i_pm,
    input  sym_t                            i_sym,
    output logic [NUM_STATES-1:0][PM_W-1:0] o_pm,
    output logic [NUM_STATES-1:0]           o_dec
);

    localparam logic [PM_W-1:0] PM_INF = '1;

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
        logic [PM_W:0] sum;
        sum = {1'b0, pm} + (PM_W+1)'(bm);
        return (sum >= {1'b0, PM_INF}) ? PM_INF : sum[PM_W-1:0];
    endfunction

    state_t          w_ns;
    logic [PM_W-1:0] w_cand0;
    logic [PM_W-1:0] w_cand1;

    // Predecessors of {x,b} are {0,x} and {1,x}; a tie keeps p=0
    always_comb begin
        o_pm    = '0;
        o_dec   = '0;
        w_ns    = '0;
        w_cand0 = '0;
        w_cand1 = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            w_ns     = 2'(i);
            w_cand0  = sat_add(i_pm[{1'b0, w_ns[1]}],
                               hamming(i_sym, expected_sym(1'b0, w_ns[1], w_ns[0])));
            w_cand1  = sat_add(i_pm[{1'b1, w_ns[1]}],
                               hamming(i_sym, expected_sym(1'b1, w_ns[1], w_ns[0])));
            o_dec[i] = (w_cand1 < w_cand0);
            o_pm[i]  = o_dec[i] ? w_cand1 : w_cand0;
        end
    end

endmodule

// File: rtl/viterbi_decoder.sv
// Frame-based hard-decision Viterbi decoder: ACS per symbol, traceback, in-order bit output.
// Optional VITDEC_METRIC_OUT_EN adds frame_metric (winning path metric of the last frame).
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter  int unsigned FRAME_LEN = 64,
    localparam int unsigned PM_W      = $clog2(2*FRAME_LEN+1)+1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_sym,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last
`ifdef VITDEC_METRIC_OUT_EN
    ,
    output logic [PM_W-1:0] frame_metric
`endif
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN+1);
    localparam int unsigned ADR_W = $clog2(FRAME_LEN);
    localparam logic [PM_W-1:0] PM_INF = '1;
    localparam logic [NUM_STATES-1:0][PM_W-1:0] PM_INIT = {PM_INF, PM_INF, PM_INF, {PM_W{1'b0}}};

    fsm_t r_state;
    fsm_t w_state_nxt;

    logic [NUM_STATES-1:0][PM_W-1:0] r_pm;
    logic [NUM_STATES-1:0][PM_W-1:0] w_pm_new;
    logic [NUM_STATES-1:0]           w_dec;
    state_t                          w_best;

    logic [NUM_STATES-1:0] r_dec_mem [FRAME_LEN];
    logic                  r_bit_mem [FRAME_LEN];

    logic [CNT_W-1:0] r_count;
    logic [ADR_W-1:0] r_len_m1;
    logic [ADR_W-1:0] r_tb_addr;
    logic [ADR_W-1:0] r_out_idx;
    logic [ADR_W-1:0] w_out_idx_nxt;
    state_t           r_tb_state;

    logic r_in_ready;
    logic r_out_valid;
    logic r_out_bit;
    logic r_out_last;

    logic w_accept;
    logic w_frame_end;
    logic w_out_hs;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_bit   = r_out_bit;
    assign out_last  = r_out_last;

    assign w_accept      = in_valid && r_in_ready;
    assign w_frame_end   = w_accept && (in_last || (r_count == CNT_W'(FRAME_LEN - 1)));
    assign w_out_hs      = r_out_valid && out_ready;
    assign w_out_idx_nxt = r_out_idx + ADR_W'(1);

    viterbi_acs #(
        .PM_W (PM_W)
    ) u_acs (
        .i_pm  (r_pm),
        .i_sym (in_sym),
        .o_pm  (w_pm_new),
        .o_dec (w_dec)
    );

    // Traceback start: lowest-index state holding the minimum updated metric
    always_comb begin
        w_best = '0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (w_pm_new[2'(i)] < w_pm_new[w_best]) begin
                w_best = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, ACS: begin
                if (w_frame_end) begin
                    w_state_nxt = TRACE;
                end else if (w_accept) begin
                    w_state_nxt = ACS;
                end
            end
            TRACE: begin
                if (r_tb_addr == '0) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                if (w_out_hs && r_out_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Decision and decoded-bit storage; traceback writes bits back-to-front
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dec_mem[ADR_W'(r_count)] <= w_dec;
        end
        if (r_state == TRACE) begin
            r_bit_mem[r_tb_addr] <= r_tb_state[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pm        <= PM_INIT;
            r_count     <= '0;
            r_len_m1    <= '0;
            r_tb_addr   <= '0;
            r_tb_state  <= '0;
            r_out_idx   <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == IDLE) || (w_state_nxt == ACS);
            case (r_state)
                IDLE, ACS: begin
                    if (w_accept) begin
                        r_pm    <= w_pm_new;
                        r_count <= r_count + CNT_W'(1);
                        if (w_frame_end) begin
                            r_len_m1   <= ADR_W'(r_count);
                            r_tb_addr  <= ADR_W'(r_count);
                            r_tb_state <= w_best;
                        end
                    end
                end
                TRACE: begin
                    r_tb_state <= {r_dec_mem[r_tb_addr][r_tb_state], r_tb_state[1]};
                    r_tb_addr  <= r_tb_addr - ADR_W'(1);
                    r_out_idx  <= '0;
                end
                OUT: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_bit   <= r_bit_mem[r_out_idx];
                        r_out_last  <= (r_out_idx == r_len_m1);
                    end else if (w_out_hs) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_bit   <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_pm        <= PM_INIT;
                            r_count     <= '0;
                        end else begin
                            r_out_idx  <= w_out_idx_nxt;
                            r_out_bit  <= r_bit_mem[w_out_idx_nxt];
                            r_out_last <= (w_out_idx_nxt == r_len_m1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef VITDEC_METRIC_OUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_metric <= '0;
        end else if (w_frame_end) begin
            frame_metric <= w_pm_new[w_best];
        end
    end
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed self-checking bench for viterbi_decoder (small FRAME_LEN to reach the length boundary).
module tb_viterbi_decoder;

    localparam int unsigned FL  = 10;
    localparam int unsigned PMW = $clog2(2*FL+1)+1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sym;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic       out_last;
`ifdef VITDEC_METRIC_OUT_EN
    logic [PMW-1:0] frame_metric;
`endif

    viterbi_decoder #(
        .FRAME_LEN (FL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last)
`ifdef VITDEC_METRIC_OUT_EN
        ,
        .frame_metric (frame_metric)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int last_acc = 0;

    logic [1:0] syms     [0:63];
    logic       exp_bits [0:63];
    logic       data     [0:63];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference convolutional encoder: state {p,x}, symbol {p^x, p^b}
    task automatic encode(input int n);
        logic p = 1'b0;
        logic x = 1'b0;
        for (int i = 0; i < n; i++) begin
            syms[i]     = {p ^ x, p ^ data[i]};
            exp_bits[i] = data[i];
            p = x;
            x = data[i];
        end
    endtask

    task automatic load_known();
        syms[0] = 2'b01; syms[1] = 2'b10; syms[2] = 2'b10;
        syms[3] = 2'b11; syms[4] = 2'b01; syms[5] = 2'b11;
        exp_bits[0] = 1'b1; exp_bits[1] = 1'b0; exp_bits[2] = 1'b1;
        exp_bits[3] = 1'b1; exp_bits[4] = 1'b0; exp_bits[5] = 1'b0;
    endtask

    task automatic send_sym(input logic [1:0] s, input logic last, input string tag);
        int guard = 0;
        in_valid = 1'b1;
        in_sym   = s;
        in_last  = last;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_accept_timeout"}, 32'(guard < 200), 32'd1);
        @(posedge clk); #1;
        last_acc = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit use_last, input string tag);
        for (int i = 0; i < n; i++) begin
            send_sym(syms[i], use_last && (i == n - 1), tag);
        end
    endtask

    task automatic recv(input int n, input int take, input bit bp, input int lat, input string tag);
        int   k = 0;
        int   guard = 0;
        int   ph = 0;
        bit   stalled = 1'b0;
        bit   seen = 1'b0;
        bit   ir_bad = 1'b0;
        logic prev_bit = 1'b0;
        while (k < take && guard < 400) begin
            out_ready = bp ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
            if (in_ready !== 1'b0) ir_bad = 1'b1;
            if (out_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    check({tag, "_latency"}, 32'(cyc - last_acc), 32'(lat));
                end
                if (stalled) check($sformatf("%s_stable%0d", tag, k), 32'(out_bit), 32'(prev_bit));
                if (out_ready) begin
                    check($sformatf("%s_bit%0d", tag, k), 32'(out_bit), 32'(exp_bits[k]));
                    check($sformatf("%s_last%0d", tag, k), 32'(out_last), 32'(k == n - 1));
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled  = 1'b1;
                    prev_bit = out_bit;
                end
                ph++;
            end
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_out_timeout"}, 32'(guard < 400), 32'd1);
        check({tag, "_in_ready_low"}, 32'(ir_bad), 32'd0);
        if (take == n) begin
            check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
            check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sym    = 2'b00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bit", 32'(out_bit), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
`ifdef VITDEC_METRIC_OUT_EN
        check("rst_metric", 32'(frame_metric), 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("rel_in_ready_high", 32'(in_ready), 32'd1);

        // All-zero frame of 8 symbols
        for (int i = 0; i < 8; i++) begin
            syms[i]     = 2'b00;
            exp_bits[i] = 1'b0;
        end
        send_frame(8, 1'b1, "zero");
        recv(8, 8, 1'b0, 9, "zero");
`ifdef VITDEC_METRIC_OUT_EN
        check("zero_metric", 32'(frame_metric), 32'd0);
`endif

        // Known pattern 1,0,1,1,0,0
        load_known();
        send_frame(6, 1'b1, "known");
        recv(6, 6, 1'b0, 7, "known");
`ifdef VITDEC_METRIC_OUT_EN
        check("known_metric", 32'(frame_metric), 32'd0);
`endif

        // One channel error on the third symbol
        load_known();
        syms[2] = 2'b00;
        send_frame(6, 1'b1, "err1");
        recv(6, 6, 1'b0, 7, "err1");
`ifdef VITDEC_METRIC_OUT_EN
        check("err1_metric", 32'(frame_metric), 32'd1);
`endif

        // Output backpressure 1,0,0,1
        load_known();
        send_frame(6, 1'b1, "bp");
        recv(6, 6, 1'b1, 7, "bp");

        // Full-length frame closed by the count, in_last never asserted
        data[0] = 1'b1; data[1] = 1'b1; data[2] = 1'b0; data[3] = 1'b1; data[4] = 1'b0;
        data[5] = 1'b0; data[6] = 1'b1; data[7] = 1'b0; data[8] = 1'b1; data[9] = 1'b1;
        encode(FL);
        send_frame(FL, 1'b0, "full");
        recv(FL, FL, 1'b0, FL + 1, "full");

        // Single-symbol frame
        syms[0]     = 2'b01;
        exp_bits[0] = 1'b1;
        send_frame(1, 1'b1, "one");
        recv(1, 1, 1'b0, 2, "one");

        // Reset in the middle of output, then a clean frame
        load_known();
        send_frame(6, 1'b1, "pre_rst");
        recv(6, 3, 1'b0, 7, "pre_rst");
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("midrst_in_ready_high", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        load_known();
        send_frame(6, 1'b1, "post_rst");
        recv(6, 6, 1'b0, 7, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
